// File: rtl/delay_tap_scheduler.sv
// Shares one single-port sample RAM between the dry write stream and NUM_TAPS
// delayed read taps, averaging dry plus valid taps into a chorus/echo mix.
module delay_tap_scheduler #(
  parameter int WIDTH        = 16,
  parameter int ADDR_W       = 15,
  parameter int NUM_TAPS     = 3,
  parameter int READ_LATENCY = 2,
  parameter int BASE_DELAY   = 5000,
  localparam int TAP_W       = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              chorus_enable,
  input  logic              sample_valid,
  input  logic [WIDTH-1:0]  data_dry,
  input  logic              cfg_we,
  input  logic [TAP_W-1:0]  cfg_tap,
  input  logic [ADDR_W-1:0] cfg_delay,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [WIDTH-1:0]  data_wet,
  output logic              wet_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int SHIFT = $clog2(NUM_TAPS + 1);
  localparam int ACC_W = WIDTH + SHIFT;
  localparam int CNT_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]        fill_q, fill_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [WIDTH-1:0]         dry_q, dry_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]        shadow_q [NUM_TAPS];
  logic [ADDR_W-1:0]        shadow_d [NUM_TAPS];
  logic [ADDR_W-1:0]        active_q [NUM_TAPS];
  logic [ADDR_W-1:0]        active_d [NUM_TAPS];
  logic [READ_LATENCY-1:0]  pipe_q, pipe_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
  logic                     mem_we_q, mem_we_d;
  logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
  logic                     overrun_q, overrun_d;
  logic [WIDTH-1:0]         wet_hold_q, wet_hold_d;

  logic                     issue;
  logic [TAP_W-1:0]         issue_idx;
  logic [ADDR_W-1:0]        issue_fill;
  logic [WIDTH-1:0]         result;
  logic [WIDTH-1:0]         out_sample;

  assign result     = WIDTH'(acc_q >>> SHIFT);
  assign out_sample = chorus_enable ? result : dry_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    base_d      = base_q;
    dry_d       = dry_q;
    acc_d       = acc_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    overrun_d   = overrun_q;
    wet_hold_d  = wet_hold_q;
    issue       = 1'b0;
    issue_idx   = '0;
    issue_fill  = fill_q;

    // pipe tracks which in-flight reads belong to unmasked taps
    pipe_d = pipe_q << 1;
    if (pipe_q[READ_LATENCY-1]) begin
      acc_d = acc_q + {{SHIFT{mem_rdata[WIDTH-1]}}, mem_rdata};
    end

    if (cfg_we && ({1'b0, cfg_tap} < (TAP_W+1)'(NUM_TAPS))) begin
      shadow_d[cfg_tap] = cfg_delay;
    end

    case (state_q)
      S_IDLE: ;
      S_WRITE: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != '1) fill_d = fill_q + 1'b1;
        issue      = 1'b1;
        issue_idx  = '0;
        issue_fill = fill_d;
        cnt_d      = '0;
        state_d    = S_READ;
      end
      S_READ: begin
        if (cnt_q == CNT_W'(NUM_TAPS - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          issue     = 1'b1;
          issue_idx = TAP_W'(cnt_q + 1'b1);
          cnt_d     = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) state_d = S_OUT;
        else cnt_d = cnt_q + 1'b1;
      end
      S_OUT: begin
        wet_hold_d = out_sample;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      mem_addr_d = base_q - active_q[issue_idx];
      pipe_d[0]  = (active_q[issue_idx] != '0) && (active_q[issue_idx] <= issue_fill);
    end

    // the OUT cycle already accepts the next sample so back-to-back strobes are not lost
    if (sample_valid) begin
      if (state_q == S_IDLE || state_q == S_OUT) begin
        state_d     = S_WRITE;
        dry_d       = data_dry;
        active_d    = shadow_q;
        base_d      = wr_ptr_q;
        acc_d       = {{SHIFT{data_dry[WIDTH-1]}}, data_dry};
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_ptr_q;
        mem_wdata_d = data_dry;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      base_q      <= '0;
      dry_q       <= '0;
      acc_q       <= '0;
      pipe_q      <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      overrun_q   <= 1'b0;
      wet_hold_q  <= '0;
      for (int t = 0; t < NUM_TAPS; t++) begin
        shadow_q[t] <= ADDR_W'(BASE_DELAY * (t + 1));
        active_q[t] <= ADDR_W'(BASE_DELAY * (t + 1));
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      base_q      <= base_d;
      dry_q       <= dry_d;
      acc_q       <= acc_d;
      pipe_q      <= pipe_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      overrun_q   <= overrun_d;
      wet_hold_q  <= wet_hold_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign wet_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign overrun   = overrun_q;
  assign data_wet  = wet_valid ? out_sample : wet_hold_q;

endmodule

// File: tb/tb_delay_tap_scheduler.sv
// Bench for delay_tap_scheduler: a default-size instance and a 16-deep instance
// share stimulus; a reference model fills per-instance scoreboards.
module tb_delay_tap_scheduler;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        chorus_en = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] data_dry = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_tap = '0;
  logic [14:0] cfg_delay = '0;

  logic [14:0] a_mem_addr;
  logic        a_mem_we;
  logic [15:0] a_mem_wdata, a_rdata, a_wet;
  logic        a_wv, a_busy, a_ovr;
  logic [3:0]  b_mem_addr;
  logic        b_mem_we;
  logic [15:0] b_mem_wdata, b_rdata, b_wet;
  logic        b_wv, b_busy, b_ovr;

  logic [15:0] ram_a [32768];
  logic [15:0] ram_b [16];

  logic signed [15:0] mmem [2][32768];
  int mptr [2];
  int mfill [2];
  int msh [2][3];
  int depth [2] = '{32768, 16};

  exp_t q_a [$];
  exp_t q_b [$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  delay_tap_scheduler #(.WIDTH(16), .ADDR_W(15), .NUM_TAPS(3), .READ_LATENCY(2), .BASE_DELAY(5000)) dut_a (
    .clk_in(clk), .rst_in(rst), .chorus_enable(chorus_en), .sample_valid(sample_valid),
    .data_dry(data_dry), .cfg_we(cfg_we), .cfg_tap(cfg_tap), .cfg_delay(cfg_delay),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_wdata(a_mem_wdata), .mem_rdata(a_rdata),
    .data_wet(a_wet), .wet_valid(a_wv), .busy(a_busy), .overrun(a_ovr));

  delay_tap_scheduler #(.WIDTH(16), .ADDR_W(4), .NUM_TAPS(3), .READ_LATENCY(2), .BASE_DELAY(1)) dut_b (
    .clk_in(clk), .rst_in(rst), .chorus_enable(chorus_en), .sample_valid(sample_valid),
    .data_dry(data_dry), .cfg_we(cfg_we), .cfg_tap(cfg_tap), .cfg_delay(cfg_delay[3:0]),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata),
    .data_wet(b_wet), .wet_valid(b_wv), .busy(b_busy), .overrun(b_ovr));

  // Two-cycle read latency RAMs: one registered stage after the address register
  always @(posedge clk) begin
    if (a_mem_we) ram_a[a_mem_addr] <= a_mem_wdata;
    if (b_mem_we) ram_b[b_mem_addr] <= b_mem_wdata;
    a_rdata <= ram_a[a_mem_addr];
    b_rdata <= ram_b[b_mem_addr];
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_wv) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("[TB] FAIL a_unexpected_wet: got data_wet %0d with wet_valid, expected no output", $signed(a_wet));
      end else begin
        e = q_a.pop_front();
        if (a_wet !== e.data) begin
          errors++;
          $display("[TB] FAIL a_data_wet: got %0d expected %0d", $signed(a_wet), $signed(e.data));
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("[TB] FAIL a_latency: got cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
    if (!rst && b_wv) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("[TB] FAIL b_unexpected_wet: got data_wet %0d with wet_valid, expected no output", $signed(b_wet));
      end else begin
        e = q_b.pop_front();
        if (b_wet !== e.data) begin
          errors++;
          $display("[TB] FAIL b_data_wet: got %0d expected %0d", $signed(b_wet), $signed(e.data));
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("[TB] FAIL b_latency: got cycle %0d expected %0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mptr[k] = 0;
      mfill[k] = 0;
    end
    msh[0] = '{5000, 10000, 15000};
    msh[1] = '{1, 2, 3};
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_sample(input logic signed [15:0] x);
    exp_t e;
    int wp, sum, d;
    for (int k = 0; k < 2; k++) begin
      wp = mptr[k];
      mmem[k][wp] = x;
      mptr[k] = (wp + 1) % depth[k];
      if (mfill[k] < depth[k] - 1) mfill[k]++;
      sum = x;
      for (int t = 0; t < 3; t++) begin
        d = msh[k][t];
        if (d != 0 && d <= mfill[k]) sum += mmem[k][(wp - d + depth[k]) % depth[k]];
      end
      e.data = chorus_en ? 16'(sum >>> 2) : x;
      e.cyc  = cyc + 7;
      if (k == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b0;
    cfg_we = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_sample(input logic signed [15:0] x);
    @(negedge clk);
    sample_valid = 1'b1;
    data_dry = x;
    model_sample(x);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic cfg_write(input int tap, input int delay);
    @(negedge clk);
    cfg_we = 1'b1;
    cfg_tap = 2'(tap);
    cfg_delay = 15'(delay);
    if (tap < 3) begin
      msh[0][tap] = delay & 32'h7FFF;
      msh[1][tap] = delay & 32'hF;
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || b_busy) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: got busy after %0d cycles expected idle", n);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if (a_wet !== 16'd0 || a_wv !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_wet: got data_wet %0d wet_valid %0b expected 0 0", a_wet, a_wv);
    end
    checks++;
    if (a_busy !== 1'b0 || a_ovr !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_status: got busy %0b overrun %0b expected 0 0", a_busy, a_ovr);
    end
    checks++;
    if (a_mem_we !== 1'b0 || a_mem_addr !== 15'd0 || a_mem_wdata !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_mem: got we %0b addr %0d wdata %0d expected 0 0 0", a_mem_we, a_mem_addr, a_mem_wdata);
    end
    send_sample(16'sd1000);
    checks++;
    if (a_mem_we !== 1'b1 || a_mem_addr !== 15'd0 || a_mem_wdata !== 16'd1000) begin
      errors++;
      $display("[TB] FAIL first_write: got we %0b addr %0d wdata %0d expected 1 0 1000", a_mem_we, a_mem_addr, a_mem_wdata);
    end
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_high: got %0b expected 1", a_busy);
    end
    wait_idle();
  endtask

  task automatic test_impulse();
    apply_reset();
    for (int t = 0; t < 3; t++) cfg_write(t, t + 1);
    send_sample(16'sd4000);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      send_sample(16'sd0);
      wait_idle();
    end
  endtask

  task automatic test_back_to_back();
    send_sample(-16'sd800);
    repeat (5) @(negedge clk);
    send_sample(16'sd1200);
    checks++;
    if (a_mem_we !== 1'b1 || a_mem_wdata !== 16'd1200) begin
      errors++;
      $display("[TB] FAIL back_to_back_write: got we %0b wdata %0d expected 1 1200", a_mem_we, a_mem_wdata);
    end
    wait_idle();
    checks++;
    if (a_ovr !== 1'b0 || b_ovr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back_overrun: got %0b %0b expected 0 0", a_ovr, b_ovr);
    end
  endtask

  task automatic test_overrun();
    send_sample(16'sd300);
    @(negedge clk);
    sample_valid = 1'b1;
    data_dry = 16'sd7777;
    @(negedge clk);
    sample_valid = 1'b0;
    wait_idle();
    checks++;
    if (a_ovr !== 1'b1 || b_ovr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set: got %0b %0b expected 1 1", a_ovr, b_ovr);
    end
    send_sample(16'sd500);
    wait_idle();
    checks++;
    if (a_ovr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_sticky: got %0b expected 1", a_ovr);
    end
  endtask

  task automatic test_config_shadow();
    apply_reset();
    cfg_write(0, 1);
    cfg_write(1, 0);
    cfg_write(2, 0);
    for (int i = 1; i <= 8; i++) begin
      send_sample(16'(i * 100));
      wait_idle();
    end
    send_sample(16'sd1000);
    cfg_write(0, 7);
    checks++;
    if (a_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cfg_while_busy: got busy %0b expected 1", a_busy);
    end
    wait_idle();
    send_sample(16'sd2000);
    wait_idle();
    cfg_write(3, 2);
    send_sample(-16'sd600);
    wait_idle();
  endtask

  task automatic test_wrap();
    apply_reset();
    cfg_write(0, 15);
    cfg_write(1, 0);
    cfg_write(2, 0);
    for (int i = 1; i <= 40; i++) begin
      send_sample(16'(i));
      checks++;
      if (b_mem_addr !== 4'((i - 1) % 16)) begin
        errors++;
        $display("[TB] FAIL wrap_write_addr: got %0d expected %0d", b_mem_addr, (i - 1) % 16);
      end
      wait_idle();
    end
  endtask

  task automatic test_bypass_and_midop_reset();
    chorus_en = 1'b0;
    send_sample(-16'sd12345);
    checks++;
    if (a_mem_we !== 1'b1 || a_mem_wdata !== 16'hCFC7) begin
      errors++;
      $display("[TB] FAIL bypass_write: got we %0b wdata %0h expected 1 cfc7", a_mem_we, a_mem_wdata);
    end
    wait_idle();
    chorus_en = 1'b1;
    send_sample(16'sd2222);
    @(negedge clk);
    apply_reset();
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_wet !== 16'd0 || a_mem_addr !== 15'd0 || a_mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got busy %0b wet %0d addr %0d we %0b expected 0 0 0 0", a_busy, a_wet, a_mem_addr, a_mem_we);
    end
    repeat (8) @(negedge clk);
    send_sample(16'sd444);
    checks++;
    if (a_mem_addr !== 15'd0 || b_mem_addr !== 4'd0 || a_mem_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_wr_ptr: got addr %0d %0d we %0b expected 0 0 1", a_mem_addr, b_mem_addr, a_mem_we);
    end
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_a[i] = '0;
      mmem[0][i] = '0;
      mmem[1][i] = '0;
    end
    for (int i = 0; i < 16; i++) ram_b[i] = '0;
    test_reset();
    test_impulse();
    test_back_to_back();
    test_overrun();
    test_config_shadow();
    test_wrap();
    test_bypass_and_midop_reset();
    repeat (10) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_outputs: got %0d %0d pending expected 0 0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
